muldiv_sequencer: RTL and testbench

// - Multi-cycle sequencer for RV32M ops (ALUOp=2'b10, Funct7=7'b0000001) that the single-cycle ALU cannot execute.
// - Sits beside the ALU in EX. The controller issues an op via a valid/ready handshake, and the core stalls on busy.
// - The result returns through a valid/ready handshake.
// - Iterative radix-2 datapath: shift-add multiply, restoring divide.

---
 rtl/muldiv_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Iterative RV32M multiply/divide sequencer placed beside the EX ALU.
//            Compile-time option MULDIV_EARLY_OUT_EN enables early termination.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_W      = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            req_funct3,
   input  logic [DATA_WIDTH-1:0] req_a,
   input  logic [DATA_WIDTH-1:0] req_b,
   input  logic                  flush,
   output logic                  busy,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data
);

   localparam logic [2:0] c_MUL    = 3'b000;
   localparam logic [2:0] c_MULH   = 3'b001;
   localparam logic [2:0] c_MULHSU = 3'b010;
   localparam logic [2:0] c_MULHU  = 3'b011;
   localparam logic [2:0] c_DIV    = 3'b100;
   localparam logic [2:0] c_DIVU   = 3'b101;
   localparam logic [2:0] c_REM    = 3'b110;

   localparam logic [CNT_W-1:0]      c_FULL = CNT_W'(DATA_WIDTH);
   localparam logic [CNT_W-1:0]      c_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] c_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                    state_q,      state_d;
   logic [2:0]                f3_q,         f3_d;
   logic [DATA_WIDTH-1:0]     a_q,          a_d;
   logic                      neg_q,        neg_d;
   logic                      neg_rem_q,    neg_rem_d;
   logic                      div0_q,       div0_d;
   logic                      ovf_q,        ovf_d;
   logic [CNT_W-1:0]          cnt_q,        cnt_d;
   logic [2*DATA_WIDTH-1:0]   mcand_q,      mcand_d;
   logic [DATA_WIDTH-1:0]     mplier_q,     mplier_d;
   logic [2*DATA_WIDTH-1:0]   acc_q,        acc_d;
   logic [DATA_WIDTH-1:0]     dsr_q,        dsr_d;
   logic [DATA_WIDTH-1:0]     dvd_q,        dvd_d;
   logic [DATA_WIDTH-1:0]     quo_q,        quo_d;
   logic [DATA_WIDTH-1:0]     rem_q,        rem_d;
   logic                      resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0]     resp_data_q,  resp_data_d;

   // Request decode: which operands are treated as signed, and the special divides
   logic                      w_a_sgn, w_b_sgn, w_sa, w_sb, w_div0, w_ovf;
   logic [DATA_WIDTH-1:0]     w_amag, w_bmag;

   assign w_a_sgn = (req_funct3 != c_MULHU) && (req_funct3[2] ? !req_funct3[0] : 1'b1);
   assign w_b_sgn = (req_funct3 == c_MUL) || (req_funct3 == c_MULH) ||
                    (req_funct3 == c_DIV) || (req_funct3 == c_REM);
   assign w_sa    = w_a_sgn & req_a[DATA_WIDTH-1];
   assign w_sb    = w_b_sgn & req_b[DATA_WIDTH-1];
   assign w_amag  = w_sa ? -req_a : req_a;
   assign w_bmag  = w_sb ? -req_b : req_b;
   assign w_div0  = (req_b == '0);
   assign w_ovf   = ((req_funct3 == c_DIV) || (req_funct3 == c_REM)) &&
                    (req_a == c_MIN) && (req_b == '1);

   // One radix-2 step of each datapath
   logic [2*DATA_WIDTH-1:0]   w_acc_add;
   logic [DATA_WIDTH-1:0]     w_mplier_nxt;
   logic [DATA_WIDTH:0]       w_rsh, w_diff;
   logic                      w_ge;
   logic [DATA_WIDTH-1:0]     w_rem_nxt, w_dvd_nxt, w_quo_nxt;
   logic [CNT_W-1:0]          w_cnt_inc;
   logic                      w_last;

   assign w_acc_add    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign w_mplier_nxt = mplier_q >> 1;
   assign w_rsh        = {rem_q, dvd_q[DATA_WIDTH-1]};
   assign w_diff       = w_rsh - {1'b0, dsr_q};
   assign w_ge         = !w_diff[DATA_WIDTH];
   assign w_rem_nxt    = w_ge ? w_diff[DATA_WIDTH-1:0] : w_rsh[DATA_WIDTH-1:0];
   assign w_dvd_nxt    = dvd_q << 1;
   assign w_quo_nxt    = {quo_q[DATA_WIDTH-2:0], w_ge};
   assign w_cnt_inc    = (cnt_q == c_FULL) ? cnt_q : cnt_q + CNT_W'(1);
   assign w_last       = (cnt_q == c_LAST);

   logic                      w_mul_fin, w_div_fin;
   logic [DATA_WIDTH-1:0]     w_quo_step;

`ifdef MULDIV_EARLY_OUT_EN
   // Once no dividend bits and no partial remainder are left, the remaining
   // quotient bits are all zero, so the quotient only needs aligning.
   assign w_mul_fin  = w_last || (w_mplier_nxt == '0);
   assign w_div_fin  = w_last || ((w_rem_nxt == '0) && (w_dvd_nxt == '0));
   assign w_quo_step = w_quo_nxt << (c_FULL - w_cnt_inc);
`else
   assign w_mul_fin  = w_last;
   assign w_div_fin  = w_last;
   assign w_quo_step = w_quo_nxt;
`endif

   logic [2*DATA_WIDTH-1:0]   w_prod;
   logic [DATA_WIDTH-1:0]     w_quo_s, w_rem_s, w_result;

   assign w_prod  = neg_q     ? -acc_q : acc_q;
   assign w_quo_s = neg_q     ? -quo_q : quo_q;
   assign w_rem_s = neg_rem_q ? -rem_q : rem_q;

   always_comb begin
      w_result = '0;
      case (f3_q)
         c_MUL:                    w_result = w_prod[DATA_WIDTH-1:0];
         c_MULH, c_MULHSU, c_MULHU: w_result = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
         c_DIV, c_DIVU:            w_result = div0_q ? '1 : (ovf_q ? c_MIN : w_quo_s);
         default:                  w_result = div0_q ? a_q : (ovf_q ? '0 : w_rem_s);
      endcase
   end

   always_comb begin
      state_d      = state_q;
      f3_d         = f3_q;
      a_d          = a_q;
      neg_d        = neg_q;
      neg_rem_d    = neg_rem_q;
      div0_d       = div0_q;
      ovf_d        = ovf_q;
      cnt_d        = cnt_q;
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      acc_d        = acc_q;
      dsr_d        = dsr_q;
      dvd_d        = dvd_q;
      quo_d        = quo_q;
      rem_d        = rem_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d   = ST_BUSY;
               f3_d      = req_funct3;
               a_d       = req_a;
               neg_d     = w_sa ^ w_sb;
               neg_rem_d = w_sa;
               div0_d    = w_div0;
               ovf_d     = w_ovf;
               cnt_d     = '0;
               mcand_d   = {{DATA_WIDTH{1'b0}}, w_amag};
               mplier_d  = w_bmag;
               acc_d     = '0;
               dvd_d     = w_amag;
               dsr_d     = w_bmag;
               quo_d     = '0;
               rem_d     = '0;
            end
         end
         ST_BUSY: begin
            cnt_d = w_cnt_inc;
            if (f3_q[2]) begin
               if (div0_q || ovf_q) begin
                  state_d = ST_DONE;
               end else begin
                  rem_d = w_rem_nxt;
                  dvd_d = w_dvd_nxt;
                  quo_d = w_div_fin ? w_quo_step : w_quo_nxt;
                  if (w_div_fin) state_d = ST_DONE;
               end
            end else begin
               acc_d    = w_acc_add;
               mcand_d  = mcand_q << 1;
               mplier_d = w_mplier_nxt;
               if (w_mul_fin) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // First DONE cycle applies the result sign; the response then holds.
            if (!resp_valid_q) begin
               resp_valid_d = 1'b1;
               resp_data_d  = w_result;
            end else if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (flush) begin
         state_d      = ST_IDLE;
         resp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         f3_q         <= '0;
         a_q          <= '0;
         neg_q        <= 1'b0;
         neg_rem_q    <= 1'b0;
         div0_q       <= 1'b0;
         ovf_q        <= 1'b0;
         cnt_q        <= '0;
         mcand_q      <= '0;
         mplier_q     <= '0;
         acc_q        <= '0;
         dsr_q        <= '0;
         dvd_q        <= '0;
         quo_q        <= '0;
         rem_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         f3_q         <= f3_d;
         a_q          <= a_d;
         neg_q        <= neg_d;
         neg_rem_q    <= neg_rem_d;
         div0_q       <= div0_d;
         ovf_q        <= ovf_d;
         cnt_q        <= cnt_d;
         mcand_q      <= mcand_d;
         mplier_q     <= mplier_d;
         acc_q        <= acc_d;
         dsr_q        <= dsr_d;
         dvd_q        <= dvd_d;
         quo_q        <= quo_d;
         rem_q        <= rem_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Self-checking bench for muldiv_sequencer (default build) against
//            an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

   localparam logic [31:0] c_MIN = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic        flush = 1'b0;
   logic        busy;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_data;

   int errors = 0;
   int checks = 0;

   muldiv_sequencer #(.DATA_WIDTH(32), .CNT_W(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_funct3 (req_funct3),
      .req_a      (req_a),
      .req_b      (req_b),
      .flush      (flush),
      .busy       (busy),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data)
   );

   always #5 clk = ~clk;

   // Reference: full-precision integer arithmetic with the RISC-V special cases.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      int sa, sb;
      sa = a;
      sb = b;
      case (f)
         3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0]; end
         3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
         3'd2: begin p = {{32{a[31]}}, a} * {32'h0, b};       return p[63:32]; end
         3'd3: begin p = {32'h0, a} * {32'h0, b};             return p[63:32]; end
         3'd4: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (a == c_MIN && b == 32'hFFFF_FFFF) return c_MIN;
            return 32'(sa / sb);
         end
         3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'h0) return a;
            if (a == c_MIN && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(sa % sb);
         end
         default: return (b == 32'h0) ? a : a % b;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && (b == 32'h0 || (!f[0] && a == c_MIN && b == 32'hFFFF_FFFF))) return 2;
      return 33;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return c_MIN;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom();
      endcase
   endfunction

   // Issues one op, waits (bounded) for the result and takes it.
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
      int guard;
      guard = 0;
      while (!req_ready && guard < 100) begin
         @(posedge clk); #1; guard++;
      end
      req_valid = 1'b1; req_funct3 = f; req_a = a; req_b = b;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      res = resp_data;
      if (resp_valid) begin
         resp_ready = 1'b1;
         @(posedge clk); #1;
         resp_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
      checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data got=%h exp=0", resp_data); end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [2:0]  f [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd0};
      logic [31:0] a [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, c_MIN, 32'd6};
      logic [31:0] b [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                              32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd3};
      logic [31:0] e [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, c_MIN, 32'd18};
      int          l [12] = '{33, 33, 33, 33, 33, 33, 33, 33, 2, 2, 2, 33};
      logic [31:0] res;
      int          lat;
      for (int i = 0; i < 12; i++) begin
         do_op(f[i], a[i], b[i], res, lat);
         checks++;
         if (res !== e[i]) begin
            errors++; $display("FAIL directed_data[%0d] f3=%0d got=%h exp=%h", i, f[i], res, e[i]);
         end
         checks++;
         if (lat != l[i]) begin
            errors++; $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat, l[i]);
         end
      end
   endtask

   task automatic test_flush();
      logic [31:0] res;
      int          lat;
      int          seen;
      req_valid = 1'b1; req_funct3 = 3'd5; req_a = 32'd1000; req_b = 32'd3;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1; flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_req_ready got=%b exp=1", req_ready); end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (resp_valid) seen++;
         @(posedge clk); #1;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_resp got=%0d exp=0", seen); end
      // Request arriving together with flush must be dropped
      req_valid = 1'b1; flush = 1'b1; req_funct3 = 3'd0; req_a = 32'd2; req_b = 32'd2;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_req_drop got=%b exp=0", busy); end
      do_op(3'd0, 32'd6, 32'd7, res, lat);
      checks++; if (res !== 32'd42) begin errors++; $display("FAIL flush_then_mul got=%h exp=%h", res, 32'd42); end
   endtask

   task automatic test_hold();
      logic [31:0] exp_v;
      int          guard;
      exp_v = model(3'd0, 32'h1234, 32'h10);
      req_valid = 1'b1; req_funct3 = 3'd0; req_a = 32'h1234; req_b = 32'h10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      guard = 0;
      while (!resp_valid && guard < 200) begin @(posedge clk); #1; guard++; end
      checks++; if (!resp_valid) begin errors++; $display("FAIL hold_timeout got=%b exp=1", resp_valid); end
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1; req_funct3 = 3'($urandom_range(0, 7)); req_a = $urandom(); req_b = $urandom();
         @(posedge clk); #1;
         checks++;
         if (resp_valid !== 1'b1 || resp_data !== exp_v || busy !== 1'b1) begin
            errors++; $display("FAIL hold_stable[%0d] valid=%b data=%h busy=%b exp data=%h", i, resp_valid, resp_data, busy, exp_v);
         end
      end
      req_valid = 1'b0; resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL hold_release valid=%b ready=%b exp 0/1", resp_valid, req_ready);
      end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_no_accept busy=%b exp=0", busy); end
   endtask

   task automatic test_random();
      logic [2:0]  f;
      logic [31:0] a, b, res;
      int          lat;
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7));
         a = pick();
         b = pick();
         do_op(f, a, b, res, lat);
         checks++;
         if (res !== model(f, a, b)) begin
            errors++; $display("FAIL random_data f3=%0d a=%h b=%h got=%h exp=%h", f, a, b, res, model(f, a, b));
         end
         checks++;
         if (lat != model_lat(f, a, b)) begin
            errors++; $display("FAIL random_latency f3=%0d got=%0d exp=%0d", f, lat, model_lat(f, a, b));
         end
      end
   endtask

   task automatic test_reset_mid();
      req_valid = 1'b1; req_funct3 = 3'd4; req_a = 32'd12345; req_b = 32'd17;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 32'h0) begin
         errors++; $display("FAIL reset_mid ready=%b busy=%b valid=%b data=%h exp 1/0/0/0", req_ready, busy, resp_valid, resp_data);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_flush();
      test_hold();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
